uart_tx_serializer: RTL
=======================

// Module: uart_tx_serializer
// PURPOSE
//  Transmit side of the UART: takes a parallel WIDTH-bit word, frames it
//  (start, data LSB-first, optional parity, stop) and drives it out on o_tx,
//  one bit per i_clk cycle. i_clk is the TX baud clock. Output is the exact
//  counterpart of the RX deserializer, which shifts bits in at the MSB.
// PARAMETERS
//  WIDTH  8  data word width in bits (default taken from `WIDTH in parameters.v)
// PORTS
//  i_clk         in   1      TX baud clock; all logic on rising edge
//  i_rst         in   1      asynchronous reset, active-high
//  i_data        in   WIDTH  parallel word to send
//  i_data_valid  in   1      request to send i_data (sampled only in IDLE)
//  i_par_en      in   1      1 = append parity bit
//  i_par_typ     in   1      0 = even parity, 1 = odd parity
//  o_tx          out  1      serial line; idle level 1
//  o_busy        out  1      high while a frame is in flight
// BEHAVIOUR
//  Reset (async, i_rst=1): state=IDLE, o_tx=1, o_busy=0, shift reg and bit
//   counter cleared. Takes effect immediately, including mid-frame; the line
//   returns to 1 and the aborted frame is not resumed after reset release.
//  Accept: in IDLE with i_data_valid=1 at edge N, i_data, i_par_en and
//   i_par_typ are latched. Parity = ^i_data XOR i_par_typ, computed from the
//   latched word. Inputs may change after edge N with no effect on the frame.
//  i_data_valid outside IDLE is ignored; there is no queueing.
//  FSM states, all registered (each bit is held for exactly 1 cycle):
//   IDLE   o_tx=1, o_busy=0; go to START on accept.
//   START  o_tx=0; go to DATA.
//   DATA   o_tx=shift[0], then shift right; counter counts 0..WIDTH-1.
//          At count WIDTH-1, go to PARITY if par_en, else to STOP.
//   PARITY o_tx=latched parity; go to STOP.
//   STOP   o_tx=1; go to IDLE.
//  Timing: o_tx and o_busy are registers; the start bit appears the cycle
//   after the accept edge. Frame length is WIDTH+2 cycles, or WIDTH+3 with
//   parity.
//  o_busy: 1 from the START cycle through the STOP cycle; 0 only in IDLE.
//  Back-to-back: a valid held high continuously is accepted in the first
//   IDLE cycle, giving exactly 1 idle (1) bit between frames. The output is
//   glitch-free: o_tx comes directly from a flop.
//  Bit counter width is $clog2(WIDTH) and must not wrap past WIDTH-1. The
//   counter clears on entry to START.
// TESTING
//  1. Reset while idle -> o_tx=1, o_busy=0. Assert reset mid-DATA ->
//     o_tx=1 and o_busy=0 with no clock edge required; next accept sends a
//     clean full frame.
//  2. i_data=8'hA5, par_en=0 -> o_tx over 10 cycles = 0,1,0,1,0,0,1,0,1,1;
//     o_busy high for exactly those 10 cycles.
//  3. i_data=8'hA5, par_en=1, par_typ=0 -> parity bit 0 (11 cycles).
//     Repeat with par_typ=1 -> parity bit 1.
//  4. i_data=8'h80, par_en=1, par_typ=0 -> data bits 0x7 then 1, parity 1,
//     stop 1.
//  5. Hold i_data_valid=1 with 8'h3C then 8'hC3 -> two frames separated by
//     exactly one idle 1-bit. Changing i_data mid-frame does not corrupt
//     frame 1.
//  6. Pulse i_data_valid during a frame -> ignored: no extra frame, and the
//     current frame is unchanged.
//  Checker: a loopback RX model at the same baud recovers every word and
//   flags any parity error; run 1000 random words with random par_en and
//   par_typ.

Source files
------------

// File: rtl/uart_tx_serializer_if.sv
// Handshake and serial-line bundle between a word producer and the UART
// transmit serializer. The producer (master) offers a word and its parity
// options; the serializer (slave) drives the line and its busy flag.
interface uart_tx_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] i_data;
    logic             i_data_valid;
    logic             i_par_en;
    logic             i_par_typ;
    logic             o_tx;
    logic             o_busy;

    modport master (
        output i_data,
        output i_data_valid,
        output i_par_en,
        output i_par_typ,
        input  o_tx,
        input  o_busy
    );

    modport slave (
        input  i_data,
        input  i_data_valid,
        input  i_par_en,
        input  i_par_typ,
        output o_tx,
        output o_busy
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: frames a WIDTH-bit word as start(0), data bits
// LSB first, optional parity, stop(1), one bit per baud-clock cycle.
// The line and busy flag come straight from flops, so each output value is
// computed one cycle ahead from the state being entered.
module uart_tx_serializer #(
    parameter int WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    uart_tx_serializer_if.slave    bus
);
    localparam int              CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shift, shift_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             par_bit, par_bit_n;
    logic             par_en, par_en_n;
    logic             tx, tx_n;
    logic             busy, busy_n;

    // Next state, next shift/count contents and the line value for the state being entered.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_n   = state;
        shift_n   = shift;
        cnt_n     = cnt;
        par_bit_n = par_bit;
        par_en_n  = par_en;
        tx_n      = 1'b1;

        case (state)
            IDLE: begin
                if (bus.i_data_valid) begin
                    state_n   = START;
                    shift_n   = bus.i_data;
                    par_bit_n = (^bus.i_data) ^ bus.i_par_typ;
                    par_en_n  = bus.i_par_en;
                    cnt_n     = '0;
                    tx_n      = 1'b0;
                end
            end
            START: begin
                state_n = DATA;
                tx_n    = shift[0];
                shift_n = shift >> 1;
            end
            DATA: begin
                if (cnt == LAST) begin
                    if (par_en) begin
                        state_n = PARITY;
                        tx_n    = par_bit;
                    end else begin
                        state_n = STOP;
                    end
                end else begin
                    cnt_n   = cnt + CNT_W'(1);
                    tx_n    = shift[0];
                    shift_n = shift >> 1;
                end
            end
            PARITY: begin
                state_n = STOP;
            end
            STOP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    // State register and registered line/busy outputs; reset aborts any frame at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (i_rst) begin
            state   <= IDLE;
            shift   <= '0;
            cnt     <= '0;
            par_bit <= 1'b0;
            par_en  <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            cnt     <= cnt_n;
            par_bit <= par_bit_n;
            par_en  <= par_en_n;
            tx      <= tx_n;
            busy    <= busy_n;
        end
    end

    assign bus.o_tx   = tx;
    assign bus.o_busy = busy;
endmodule
